multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control FSM that drives the processor datapath's control inputs and consumes its `opcode_out`/`zero_flag_out` outputs. It sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and asserts every state-changing enable (PC, register file, data memory) for exactly one cycle per instruction. It also provides run gating, halt and illegal-opcode status, and a retired-instruction counter for the testbench and debug.

## Interface
- `COUNT_W`, 16, width of the retired-instruction counter.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous and active-low.
- `run_en` in 1: permits starting a new instruction; sampled only in FETCH.
- `opcode_in` in 5: instruction opcode, from datapath `opcode_out`.
- `zero_flag_in` in 1: ALU zero, from datapath `zero_flag_out`.
- `pc_write_en` out 1: PC update strobe.
- `pc_src_sel` out 1: 0 selects PC+4; 1 selects the branch/jump target.
- `reg_write_en` out 1: register file write strobe.
- `mem_to_reg_sel` out 2: 00 ALU, 01 memory, 10 PC+4.
- `mem_read_en` out 1: data memory read enable.
- `mem_write_en` out 1: data memory write strobe.
- `alu_src_b_sel` out 1: 0 selects rt; 1 selects the sign-extended immediate.
- `alu_control_op` out 5: ALU operation code.
- `reg_dst_sel` out 2: 00 rt, 01 rd, 10 R7.
- `halted` out 1: high in HALT state.
- `illegal_op` out 1: sticky; set on an undefined opcode.
- `instr_retired` out COUNT_W: count of `pc_write_en` pulses; wraps modulo 2^COUNT_W.

## Operation
- **Opcodes:** ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SLT 00101, ADDI 01000, LW 01001, SW 01010, BEQ 01100, BNE 01101, JAL 01110, HALT 11111. All other opcodes are illegal.
- **ALU codes:** ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SLT 00101. For R-type instructions, the ALU code equals the opcode.
- **Opcode capture:** in FETCH with `run_en`=1, capture `opcode_in` into `ir_op` and go to DECODE. In FETCH with `run_en`=0, stay in FETCH with all enables 0.
- **DECODE:** classify `ir_op`.
  - HALT goes to HALT.
  - An illegal opcode sets `illegal_op` and goes to HALT.
  - All other opcodes go to EXECUTE.
- **EXECUTE:**
  - R-type: `alu_src_b_sel`=0, `alu_control_op`=`ir_op`; go to WRITEBACK.
  - ADDI/LW/SW: `alu_src_b_sel`=1, ALU ADD. ADDI goes to WRITEBACK; LW and SW go to MEMORY.
  - BEQ/BNE: `alu_src_b_sel`=0, ALU SUB, `pc_write_en`=1. `pc_src_sel` = `zero_flag_in` for BEQ and = !`zero_flag_in` for BNE. Go to FETCH.
  - JAL: `reg_write_en`=1, `reg_dst_sel`=10, `mem_to_reg_sel`=10, `pc_src_sel`=1, `pc_write_en`=1. Go to FETCH.
- **MEMORY:** ALU settings are held from EXECUTE.
  - LW: `mem_read_en`=1; go to WRITEBACK.
  - SW: `mem_write_en`=1, `pc_write_en`=1, `pc_src_sel`=0; go to FETCH.
- **WRITEBACK:** ALU settings are held; `reg_write_en`=1, `pc_write_en`=1, `pc_src_sel`=0; go to FETCH.
  - R-type: `reg_dst_sel`=01, `mem_to_reg_sel`=00.
  - ADDI: `reg_dst_sel`=00, `mem_to_reg_sel`=00.
  - LW: `reg_dst_sel`=00, `mem_to_reg_sel`=01, `mem_read_en`=1.
- **HALT:** absorbing; all enables 0, `halted`=1. The only exit is reset.
- **Retired counter:** `instr_retired` increments in every cycle where `pc_write_en`=1.

## Timing
- **Outputs:** all outputs are Moore functions of the state register and `ir_op`. The only exception is `pc_src_sel` in BEQ/BNE EXECUTE, which depends combinationally on `zero_flag_in` in the same cycle.
- **Cycles per instruction, FETCH to FETCH:** R-type/ADDI 4, LW 5, SW 4, BEQ/BNE/JAL 3.
- **Enable pulses:** each enable is high for exactly one cycle per instruction. The exception is `mem_read_en`, which is high for 2 cycles on LW.
- **No overlap:** `reg_write_en` and `mem_write_en` are never high in the same cycle.
- **Reset values:** with `rst`=0 at a rising edge, the state becomes FETCH and all registers clear (`illegal_op`=0, `halted`=0, `instr_retired`=0, `ir_op`=0). All outputs are then 0 (`alu_control_op`=ADD).
- **Enable gating during reset:** while `rst`=0, every write enable and `pc_write_en` is forced to 0 combinationally. This includes reset asserted mid-instruction, so a partial instruction never commits.
- **`run_en` deassertion:** ignored once an instruction has left FETCH; the instruction always completes.
- **Counter wrap:** at `instr_retired` = 2^COUNT_W−1, the next pulse gives 0.

## Structure
- **Shared package `cpu_pkg`:** opcode constants, ALU codes, `mem_to_reg`/`reg_dst` select encodings, and the state enum. The datapath uses the same package.
- **Sub-module `ctrl_decode`:** combinational; maps `ir_op` to an instruction class (R, ADDI, LW, SW, BR, JAL, HALT, ILLEGAL) and to the ALU code. The FSM instantiates it once.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with `run_en`=1 -> all enables 0, `instr_retired`=0, state FETCH; first release gives DECODE one cycle later.
- **ADD then LW:** ADD (00000) then LW (01001) ->
  - ADD: `reg_write_en` pulse in cycle 4 with `reg_dst_sel`=01.
  - LW: `mem_read_en` in cycles 4–5, `reg_write_en` in cycle 5 with `mem_to_reg_sel`=01.
  - `instr_retired`=2 after both.
- **BEQ both ways:** BEQ with `zero_flag_in`=1 -> `pc_write_en`=1 and `pc_src_sel`=1 in cycle 3. BNE with `zero_flag_in`=1 -> `pc_src_sel`=0.
- **JAL:** JAL (01110) -> single cycle with `reg_write_en`=1, `reg_dst_sel`=10, `mem_to_reg_sel`=10, `pc_write_en`=1, `pc_src_sel`=1.
- **Illegal opcode and HALT:** opcode 10101 -> `illegal_op`=1 and `halted`=1 after DECODE, no `pc_write_en`. Outputs stay frozen for 20 cycles and clear only on `rst`=0.
- **Run gating, reset mid-op, wrap:**
  - `run_en`=0 in FETCH -> no progress.
  - `rst`=0 during LW MEMORY -> no `reg_write_en` occurs.
  - COUNT_W=4 with 16 retirements -> counter reads 0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Opcodes, ALU codes, select encodings, FSM states and instruction
//               classes shared by the control FSM and the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [4:0] c_op_add  = 5'b00000;
    localparam logic [4:0] c_op_sub  = 5'b00001;
    localparam logic [4:0] c_op_and  = 5'b00010;
    localparam logic [4:0] c_op_or   = 5'b00011;
    localparam logic [4:0] c_op_xor  = 5'b00100;
    localparam logic [4:0] c_op_slt  = 5'b00101;
    localparam logic [4:0] c_op_addi = 5'b01000;
    localparam logic [4:0] c_op_lw   = 5'b01001;
    localparam logic [4:0] c_op_sw   = 5'b01010;
    localparam logic [4:0] c_op_beq  = 5'b01100;
    localparam logic [4:0] c_op_bne  = 5'b01101;
    localparam logic [4:0] c_op_jal  = 5'b01110;
    localparam logic [4:0] c_op_halt = 5'b11111;

    localparam logic [4:0] c_alu_add = 5'b00000;
    localparam logic [4:0] c_alu_sub = 5'b00001;
    localparam logic [4:0] c_alu_and = 5'b00010;
    localparam logic [4:0] c_alu_or  = 5'b00011;
    localparam logic [4:0] c_alu_xor = 5'b00100;
    localparam logic [4:0] c_alu_slt = 5'b00101;

    localparam logic [1:0] c_m2r_alu = 2'b00;
    localparam logic [1:0] c_m2r_mem = 2'b01;
    localparam logic [1:0] c_m2r_pc4 = 2'b10;

    localparam logic [1:0] c_rd_rt = 2'b00;
    localparam logic [1:0] c_rd_rd = 2'b01;
    localparam logic [1:0] c_rd_r7 = 2'b10;

    localparam logic [2:0] c_st_fetch     = 3'd0;
    localparam logic [2:0] c_st_decode    = 3'd1;
    localparam logic [2:0] c_st_execute   = 3'd2;
    localparam logic [2:0] c_st_memory    = 3'd3;
    localparam logic [2:0] c_st_writeback = 3'd4;
    localparam logic [2:0] c_st_halt      = 3'd5;

    localparam logic [2:0] c_cls_r       = 3'd0;
    localparam logic [2:0] c_cls_addi    = 3'd1;
    localparam logic [2:0] c_cls_lw      = 3'd2;
    localparam logic [2:0] c_cls_sw      = 3'd3;
    localparam logic [2:0] c_cls_br      = 3'd4;
    localparam logic [2:0] c_cls_jal     = 3'd5;
    localparam logic [2:0] c_cls_halt    = 3'd6;
    localparam logic [2:0] c_cls_illegal = 3'd7;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : Combinational opcode classifier and ALU operation lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [4:0] ir_op,
    output logic [2:0] instr_class,
    output logic [4:0] alu_code
);

    always_comb begin
        instr_class = c_cls_illegal;
        alu_code    = c_alu_add;
        case (ir_op)
            c_op_add, c_op_sub, c_op_and, c_op_or, c_op_xor, c_op_slt: begin
                instr_class = c_cls_r;
                alu_code    = ir_op;
            end
            c_op_addi: instr_class = c_cls_addi;
            c_op_lw:   instr_class = c_cls_lw;
            c_op_sw:   instr_class = c_cls_sw;
            c_op_beq, c_op_bne: begin
                instr_class = c_cls_br;
                alu_code    = c_alu_sub;
            end
            c_op_jal:  instr_class = c_cls_jal;
            c_op_halt: instr_class = c_cls_halt;
            default:   instr_class = c_cls_illegal;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control FSM
//               with run gating, halt/illegal status and a retired counter.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import cpu_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_en,
    input  logic [4:0]         opcode_in,
    input  logic               zero_flag_in,
    output logic               pc_write_en,
    output logic               pc_src_sel,
    output logic               reg_write_en,
    output logic [1:0]         mem_to_reg_sel,
    output logic               mem_read_en,
    output logic               mem_write_en,
    output logic               alu_src_b_sel,
    output logic [4:0]         alu_control_op,
    output logic [1:0]         reg_dst_sel,
    output logic               halted,
    output logic               illegal_op,
    output logic [COUNT_W-1:0] instr_retired
);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [4:0]         r_ir_op;
    logic               r_illegal;
    logic [COUNT_W-1:0] r_count;
    logic [2:0]         w_class;
    logic [4:0]         w_alu_code;
    logic               w_set_illegal;
    logic               w_pc_write;
    logic               w_reg_write;
    logic               w_mem_write;
    logic               w_imm_class;

    ctrl_decode u_ctrl_decode (
        .ir_op       (r_ir_op),
        .instr_class (w_class),
        .alu_code    (w_alu_code)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= c_st_fetch;
            r_ir_op   <= 5'b00000;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_st_fetch && run_en)
                r_ir_op <= opcode_in;
            if (w_set_illegal)
                r_illegal <= 1'b1;
            if (pc_write_en)
                r_count <= r_count + COUNT_W'(1);
        end
    end

    assign w_imm_class = (w_class == c_cls_addi) || (w_class == c_cls_lw) ||
                         (w_class == c_cls_sw);

    always_comb begin
        w_state_nxt    = r_state;
        w_set_illegal  = 1'b0;
        w_pc_write     = 1'b0;
        w_reg_write    = 1'b0;
        w_mem_write    = 1'b0;
        pc_src_sel     = 1'b0;
        mem_to_reg_sel = c_m2r_alu;
        mem_read_en    = 1'b0;
        alu_src_b_sel  = 1'b0;
        alu_control_op = c_alu_add;
        reg_dst_sel    = c_rd_rt;
        halted         = 1'b0;
        case (r_state)
            c_st_fetch: begin
                if (run_en)
                    w_state_nxt = c_st_decode;
            end
            c_st_decode: begin
                if (w_class == c_cls_halt) begin
                    w_state_nxt = c_st_halt;
                end else if (w_class == c_cls_illegal) begin
                    w_set_illegal = 1'b1;
                    w_state_nxt   = c_st_halt;
                end else begin
                    w_state_nxt = c_st_execute;
                end
            end
            c_st_execute: begin
                alu_control_op = w_alu_code;
                alu_src_b_sel  = w_imm_class;
                case (w_class)
                    c_cls_r, c_cls_addi:  w_state_nxt = c_st_writeback;
                    c_cls_lw, c_cls_sw:   w_state_nxt = c_st_memory;
                    c_cls_br: begin
                        // Branch resolves in this cycle from the live ALU zero flag.
                        w_pc_write  = 1'b1;
                        pc_src_sel  = (r_ir_op == c_op_beq) ? zero_flag_in : !zero_flag_in;
                        w_state_nxt = c_st_fetch;
                    end
                    c_cls_jal: begin
                        w_reg_write    = 1'b1;
                        reg_dst_sel    = c_rd_r7;
                        mem_to_reg_sel = c_m2r_pc4;
                        pc_src_sel     = 1'b1;
                        w_pc_write     = 1'b1;
                        w_state_nxt    = c_st_fetch;
                    end
                    default: w_state_nxt = c_st_fetch;
                endcase
            end
            c_st_memory: begin
                alu_control_op = w_alu_code;
                alu_src_b_sel  = w_imm_class;
                if (w_class == c_cls_lw) begin
                    mem_read_en = 1'b1;
                    w_state_nxt = c_st_writeback;
                end else begin
                    w_mem_write = (w_class == c_cls_sw);
                    w_pc_write  = (w_class == c_cls_sw);
                    w_state_nxt = c_st_fetch;
                end
            end
            c_st_writeback: begin
                alu_control_op = w_alu_code;
                alu_src_b_sel  = w_imm_class;
                w_reg_write    = 1'b1;
                w_pc_write     = 1'b1;
                if (w_class == c_cls_r)
                    reg_dst_sel = c_rd_rd;
                if (w_class == c_cls_lw) begin
                    mem_to_reg_sel = c_m2r_mem;
                    mem_read_en    = 1'b1;
                end
                w_state_nxt = c_st_fetch;
            end
            c_st_halt: begin
                halted = 1'b1;
            end
            default: w_state_nxt = c_st_fetch;
        endcase
    end

    // A reset landing mid-instruction must never let a partial instruction commit.
    assign pc_write_en   = w_pc_write  & rst;
    assign reg_write_en  = w_reg_write & rst;
    assign mem_write_en  = w_mem_write & rst;
    assign illegal_op    = r_illegal;
    assign instr_retired = r_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed self-checking bench for multicycle_control (COUNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic       clk;
    logic       rst;
    logic       run_en;
    logic [4:0] opcode_in;
    logic       zero_flag_in;
    logic       pc_write_en;
    logic       pc_src_sel;
    logic       reg_write_en;
    logic [1:0] mem_to_reg_sel;
    logic       mem_read_en;
    logic       mem_write_en;
    logic       alu_src_b_sel;
    logic [4:0] alu_control_op;
    logic [1:0] reg_dst_sel;
    logic       halted;
    logic       illegal_op;
    logic [3:0] instr_retired;

    int n_checks;
    int n_errors;

    logic [16:0] w_outs;

    multicycle_control #(.COUNT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .run_en         (run_en),
        .opcode_in      (opcode_in),
        .zero_flag_in   (zero_flag_in),
        .pc_write_en    (pc_write_en),
        .pc_src_sel     (pc_src_sel),
        .reg_write_en   (reg_write_en),
        .mem_to_reg_sel (mem_to_reg_sel),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .alu_src_b_sel  (alu_src_b_sel),
        .alu_control_op (alu_control_op),
        .reg_dst_sel    (reg_dst_sel),
        .halted         (halted),
        .illegal_op     (illegal_op),
        .instr_retired  (instr_retired)
    );

    assign w_outs = {pc_write_en, pc_src_sel, reg_write_en, mem_to_reg_sel, mem_read_en,
                     mem_write_en, alu_src_b_sel, alu_control_op, reg_dst_sel, halted,
                     illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] ctl(input logic pcw, input logic pcs, input logic rw,
                                        input logic [1:0] m2r, input logic mr, input logic mw,
                                        input logic asb, input logic [4:0] alu,
                                        input logic [1:0] rd, input logic h, input logic il);
        return {pcw, pcs, rw, m2r, mr, mw, asb, alu, rd, h, il};
    endfunction

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b0;
        run_en       = 1'b1;
        opcode_in    = 5'b00001;
        zero_flag_in = 1'b0;

        // Reset held two cycles with run_en high
        tick(); tick();
        check("rst_outs", w_outs, 17'h0);
        check("rst_cnt", 17'(instr_retired), 17'd0);

        // First instruction after release: SUB, DECODE one cycle later
        rst = 1'b1; #1;
        check("sub_c1", w_outs, 17'h0);
        tick(); check("sub_c2", w_outs, 17'h0);
        tick(); check("sub_c3", w_outs, ctl(0,0,0,2'b00,0,0,0,5'b00001,2'b00,0,0));
        tick(); check("sub_c4", w_outs, ctl(1,0,1,2'b00,0,0,0,5'b00001,2'b01,0,0));
        tick(); check("sub_cnt", 17'(instr_retired), 17'd1);

        // ADD, with run_en dropped mid-instruction
        opcode_in = 5'b00000; #1;
        tick(); run_en = 1'b0; #1;
        check("add_c2", w_outs, 17'h0);
        tick(); check("add_c3", w_outs, 17'h0);
        tick(); check("add_c4", w_outs, ctl(1,0,1,2'b00,0,0,0,5'b00000,2'b01,0,0));
        tick(); check("add_cnt", 17'(instr_retired), 17'd2);

        // run_en low in FETCH: no progress
        opcode_in = 5'b01001;
        tick(); tick();
        check("gate_outs", w_outs, 17'h0);
        check("gate_cnt", 17'(instr_retired), 17'd2);

        // LW
        run_en = 1'b1; #1;
        tick(); check("lw_c2", w_outs, 17'h0);
        tick(); check("lw_c3", w_outs, ctl(0,0,0,2'b00,0,0,1,5'b00000,2'b00,0,0));
        tick(); check("lw_c4", w_outs, ctl(0,0,0,2'b00,1,0,1,5'b00000,2'b00,0,0));
        tick(); check("lw_c5", w_outs, ctl(1,0,1,2'b01,1,0,1,5'b00000,2'b00,0,0));
        tick(); check("lw_cnt", 17'(instr_retired), 17'd3);

        // BEQ taken, then zero flag drops in the same cycle
        opcode_in = 5'b01100; zero_flag_in = 1'b1;
        tick(); tick();
        check("beq_c3", w_outs, ctl(1,1,0,2'b00,0,0,0,5'b00001,2'b00,0,0));
        zero_flag_in = 1'b0; #1;
        check("beq_z0_pcs", 17'(pc_src_sel), 17'd0);
        tick(); check("beq_cnt", 17'(instr_retired), 17'd4);

        // BNE with zero=1: not taken
        opcode_in = 5'b01101; zero_flag_in = 1'b1;
        tick(); tick();
        check("bne_c3", w_outs, ctl(1,0,0,2'b00,0,0,0,5'b00001,2'b00,0,0));
        zero_flag_in = 1'b0; #1;
        check("bne_z0_pcs", 17'(pc_src_sel), 17'd1);
        tick(); check("bne_cnt", 17'(instr_retired), 17'd5);

        // JAL
        opcode_in = 5'b01110;
        tick(); tick();
        check("jal_c3", w_outs, ctl(1,1,1,2'b10,0,0,0,5'b00000,2'b10,0,0));
        tick(); check("jal_cnt", 17'(instr_retired), 17'd6);

        // SW
        opcode_in = 5'b01010;
        tick(); tick();
        check("sw_c3", w_outs, ctl(0,0,0,2'b00,0,0,1,5'b00000,2'b00,0,0));
        tick(); check("sw_c4", w_outs, ctl(1,0,0,2'b00,0,1,1,5'b00000,2'b00,0,0));
        tick(); check("sw_cnt", 17'(instr_retired), 17'd7);

        // Reset during LW MEMORY: writeback never happens
        opcode_in = 5'b01001;
        tick(); tick(); tick();
        rst = 1'b0; #1;
        check("rstmem_en", 17'({pc_write_en, reg_write_en, mem_write_en}), 17'd0);
        tick();
        check("rstmem_outs", w_outs, 17'h0);
        check("rstmem_cnt", 17'(instr_retired), 17'd0);
        rst = 1'b1; run_en = 1'b0; #1;
        tick(); check("rstmem_norw", w_outs, 17'h0);

        // Reset during LW WRITEBACK: strobes gated combinationally
        run_en = 1'b1; #1;
        tick(); tick(); tick(); tick();
        rst = 1'b0; #1;
        check("rstwb_en", 17'({pc_write_en, reg_write_en, mem_write_en}), 17'd0);
        tick(); check("rstwb_cnt", 17'(instr_retired), 17'd0);
        rst = 1'b1; #1;

        // Counter wrap with COUNT_W=4
        opcode_in = 5'b01110;
        for (int i = 0; i < 15; i++) begin
            tick(); tick(); tick();
        end
        check("wrap_15", 17'(instr_retired), 17'd15);
        tick(); tick(); tick();
        check("wrap_0", 17'(instr_retired), 17'd0);

        // Illegal opcode -> sticky illegal + HALT, frozen until reset
        opcode_in = 5'b10101;
        tick(); check("ill_c2", w_outs, 17'h0);
        tick(); check("ill_halt", w_outs, ctl(0,0,0,2'b00,0,0,0,5'b00000,2'b00,1,1));
        opcode_in = 5'b00000;
        for (int i = 0; i < 20; i++) tick();
        check("ill_frozen", w_outs, ctl(0,0,0,2'b00,0,0,0,5'b00000,2'b00,1,1));
        check("ill_cnt", 17'(instr_retired), 17'd0);
        rst = 1'b0; #1;
        tick(); check("ill_clr", w_outs, 17'h0);
        rst = 1'b1; #1;

        // HALT opcode
        opcode_in = 5'b11111;
        tick(); tick();
        check("halt_op", w_outs, ctl(0,0,0,2'b00,0,0,0,5'b00000,2'b00,1,0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
